// File: rtl/id_ex_alu_issue_pkg.sv
// Shared encodings for the ID/EX ALU issue stage and its decoder.
// Holds the ALU operation codes driven to the execute ALU, the main ALUOp
// codes produced by the control unit, the R-type funct values recognised
// by the decoder, and the forwarding select codes used on both operand paths.
package id_ex_alu_issue_pkg;

  // ALU operation codes seen by the execute-stage ALU.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Main ALUOp from the control unit.
  typedef enum logic [1:0] {
    MAIN_ADD   = 2'b00,  // lw/sw address add
    MAIN_SUB   = 2'b01,  // beq compare
    MAIN_RTYPE = 2'b10,  // decode from funct
    MAIN_ILL   = 2'b11   // never produced by legal control
  } main_op_e;

  // R-type funct field values.
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Forwarding selects; the unused code 2'b11 falls back to the register path.
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_e;

  // Decoder result bundle.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       illegal;
  } alu_dec_t;

endpackage

// File: rtl/id_ex_alu_issue_alu_op_decode.sv
// Combinational ALU control decoder.
// Maps the main ALUOp plus the R-type funct field to the 3-bit ALU operation
// and an illegal flag. Undecodable combinations yield ALU_ADD with illegal=1.
// The flag is not qualified by instruction validity here, so the hazard unit
// can reuse this block; the issue stage applies its own valid gating.
// Ports:
//   main_op  in  2   main ALUOp from control
//   funct    in  6   instruction funct field
//   alu_op   out 3   ALU operation code
//   illegal  out 1   op/funct combination not recognised
module alu_op_decode
  import id_ex_alu_issue_pkg::*;
(
  input  logic [1:0] main_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal
);

  alu_dec_t dec;

  always_comb begin
    dec.alu_op  = ALU_ADD;
    dec.illegal = 1'b0;
    case (main_op_e'(main_op))
      MAIN_ADD: dec.alu_op = ALU_ADD;
      MAIN_SUB: dec.alu_op = ALU_SUB;
      MAIN_RTYPE: begin
        case (funct)
          FUNCT_ADD: dec.alu_op = ALU_ADD;
          FUNCT_SUB: dec.alu_op = ALU_SUB;
          FUNCT_AND: dec.alu_op = ALU_AND;
          FUNCT_OR:  dec.alu_op = ALU_OR;
          FUNCT_SLT: dec.alu_op = ALU_SLT;
          default:   dec.illegal = 1'b1;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign alu_op  = dec.alu_op;
  assign illegal = dec.illegal;

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX pipeline register and ALU operand issue stage.
// Captures decoded instruction fields at the end of ID, registers the ALU
// operation decoded from main ALUOp/funct, and drives the execute ALU's
// operands through EX/MEM and MEM/WB forwarding muxes. Supports stall (hold),
// flush (insert bubble) and a saturating count of bubble cycles.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_valid                ID holds a real instruction
//   i_stall, i_flush       hold contents / replace with bubble (flush wins)
//   i_alu_op_main, i_funct main ALUOp and funct to decode
//   i_rd1, i_rd2, i_imm    register read data and sign-extended immediate
//   i_alu_src              1: operand B is the immediate
//   i_fwd_a, i_fwd_b       EX-cycle forwarding selects (00/11 reg, 01 WB, 10 MEM)
//   i_ex_mem_result        EX/MEM forwarded value
//   i_mem_wb_result        MEM/WB forwarded value
//   o_valid, o_alu_op      registered valid and ALU operation
//   o_op_a, o_op_b         ALU operands
//   o_wr_data              forwarded rt for stores
//   o_illegal              registered instruction was undecodable
//   o_bubble_cnt           saturating count of cycles with o_valid=0
module id_ex_alu_issue
  import id_ex_alu_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [1:0]        i_alu_op_main,
  input  logic [5:0]        i_funct,
  input  logic [DATA_W-1:0] i_rd1,
  input  logic [DATA_W-1:0] i_rd2,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_alu_src,
  input  logic [1:0]        i_fwd_a,
  input  logic [1:0]        i_fwd_b,
  input  logic [DATA_W-1:0] i_ex_mem_result,
  input  logic [DATA_W-1:0] i_mem_wb_result,
  output logic              o_valid,
  output logic [2:0]        o_alu_op,
  output logic [DATA_W-1:0] o_op_a,
  output logic [DATA_W-1:0] o_op_b,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_illegal,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  logic              valid_q;
  logic [2:0]        alu_op_q;
  logic              illegal_q;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [DATA_W-1:0] imm_q;
  logic              alu_src_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  logic [2:0]        dec_alu_op;
  logic              dec_illegal;
  logic              valid_next;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_fwd;

  alu_op_decode u_decode (
    .main_op (i_alu_op_main),
    .funct   (i_funct),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q   <= 1'b0;
      alu_op_q  <= ALU_ADD;
      illegal_q <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      alu_src_q <= 1'b0;
    end else if (i_flush) begin
      valid_q   <= 1'b0;
      alu_op_q  <= ALU_ADD;
      illegal_q <= 1'b0;
      rd1_q     <= '0;
      rd2_q     <= '0;
      imm_q     <= '0;
      alu_src_q <= 1'b0;
    end else if (!i_stall) begin
      // A non-valid slot still captures operands but carries bubble control.
      valid_q   <= i_valid;
      alu_op_q  <= i_valid ? dec_alu_op : ALU_ADD;
      illegal_q <= i_valid & dec_illegal;
      rd1_q     <= i_rd1;
      rd2_q     <= i_rd2;
      imm_q     <= i_imm;
      alu_src_q <= i_alu_src;
    end
  end

  // Valid as it will be after this edge (reset handled separately below).
  always_comb begin
    valid_next = i_valid;
    if (i_flush)      valid_next = 1'b0;
    else if (i_stall) valid_next = valid_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bubble_cnt_q <= '0;
    end else if (!valid_next && (bubble_cnt_q != '1)) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    a_sel = rd1_q;
    case (fwd_sel_e'(i_fwd_a))
      FWD_WB:  a_sel = i_mem_wb_result;
      FWD_MEM: a_sel = i_ex_mem_result;
      default: a_sel = rd1_q;
    endcase
  end

  always_comb begin
    b_fwd = rd2_q;
    case (fwd_sel_e'(i_fwd_b))
      FWD_WB:  b_fwd = i_mem_wb_result;
      FWD_MEM: b_fwd = i_ex_mem_result;
      default: b_fwd = rd2_q;
    endcase
  end

  assign o_valid      = valid_q;
  assign o_alu_op     = alu_op_q;
  assign o_illegal    = illegal_q;
  assign o_op_a       = a_sel;
  assign o_wr_data    = b_fwd;
  // The immediate bypasses forwarding entirely.
  assign o_op_b       = alu_src_q ? imm_q : b_fwd;
  assign o_bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
module tb_id_ex_alu_issue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, valid, stall, flush, alu_src;
  logic [1:0]        alu_op_main, fwd_a, fwd_b;
  logic [5:0]        funct;
  logic [DATA_W-1:0] rd1, rd2, imm, ex_mem, mem_wb;
  logic              o_valid, o_illegal;
  logic [2:0]        o_alu_op;
  logic [DATA_W-1:0] o_op_a, o_op_b, o_wr_data;
  logic [CNT_W-1:0]  o_bubble_cnt;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  id_ex_alu_issue #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall), .i_flush(flush),
    .i_alu_op_main(alu_op_main), .i_funct(funct), .i_rd1(rd1), .i_rd2(rd2),
    .i_imm(imm), .i_alu_src(alu_src), .i_fwd_a(fwd_a), .i_fwd_b(fwd_b),
    .i_ex_mem_result(ex_mem), .i_mem_wb_result(mem_wb),
    .o_valid(o_valid), .o_alu_op(o_alu_op), .o_op_a(o_op_a), .o_op_b(o_op_b),
    .o_wr_data(o_wr_data), .o_illegal(o_illegal), .o_bubble_cnt(o_bubble_cnt)
  );

  typedef struct {
    logic        v, st, fl;
    logic [1:0]  main;
    logic [5:0]  fn;
    logic [31:0] r1, r2, im;
    logic        src;
    logic [1:0]  fa, fb;
    logic [31:0] exm, mwb;
    logic        e_valid;
    logic [2:0]  e_op;
    logic [31:0] e_a, e_b, e_wr;
    logic        e_ill;
  } vec_t;

  vec_t tbl[17];
  vec_t sb[$];

  function automatic vec_t mk(logic v, logic st, logic fl, logic [1:0] main, logic [5:0] fn,
                              logic [31:0] r1, logic [31:0] r2, logic [31:0] im, logic src,
                              logic [1:0] fa, logic [1:0] fb, logic [31:0] exm, logic [31:0] mwb,
                              logic ev, logic [2:0] eop, logic [31:0] ea, logic [31:0] eb,
                              logic [31:0] ewr, logic eill);
    vec_t t;
    t.v = v; t.st = st; t.fl = fl; t.main = main; t.fn = fn;
    t.r1 = r1; t.r2 = r2; t.im = im; t.src = src; t.fa = fa; t.fb = fb;
    t.exm = exm; t.mwb = mwb;
    t.e_valid = ev; t.e_op = eop; t.e_a = ea; t.e_b = eb; t.e_wr = ewr; t.e_ill = eill;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    valid = t.v; stall = t.st; flush = t.fl; alu_op_main = t.main; funct = t.fn;
    rd1 = t.r1; rd2 = t.r2; imm = t.im; alu_src = t.src; fwd_a = t.fa; fwd_b = t.fb;
    ex_mem = t.exm; mem_wb = t.mwb;
  endtask

  task automatic bump_cnt(logic v);
    if (!v && exp_cnt != 15) exp_cnt++;
  endtask

  task automatic check_outputs(string tag, vec_t e);
    check({tag, ".valid"},   32'(o_valid),      32'(e.e_valid));
    check({tag, ".alu_op"},  32'(o_alu_op),     32'(e.e_op));
    check({tag, ".op_a"},    o_op_a,            e.e_a);
    check({tag, ".op_b"},    o_op_b,            e.e_b);
    check({tag, ".wr_data"}, o_wr_data,         e.e_wr);
    check({tag, ".illegal"}, 32'(o_illegal),    32'(e.e_ill));
    check({tag, ".bubble"},  32'(o_bubble_cnt), 32'(exp_cnt));
  endtask

  // Simple one-cycle step for hand sequences.
  task automatic step(logic r, logic v, logic st, logic fl, logic [31:0] r1);
    @(negedge clk);
    rst = r; valid = v; stall = st; flush = fl; rd1 = r1;
    alu_op_main = 2'b00; funct = 6'h00; rd2 = '0; imm = '0; alu_src = 1'b0;
    fwd_a = 2'b00; fwd_b = 2'b00; ex_mem = '0; mem_wb = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t e;
    //              v  st fl main  fn     rd1          rd2          imm          src fa    fb    ex_mem       mem_wb         ev op     op_a         op_b         wr           ill
    tbl[0]  = mk(1, 0, 0, 2'd2, 6'h2A, 32'd5,       32'd9,       32'd0,       0, 2'd0, 2'd0, 32'd0,       32'd0,         1, 3'd5, 32'd5,       32'd9,       32'd9,       0);
    tbl[1]  = mk(1, 0, 0, 2'd0, 6'h00, 32'h100,     32'hAA,      32'h10,      1, 2'd0, 2'd2, 32'h77,      32'd0,         1, 3'd0, 32'h100,     32'h10,      32'h77,      0);
    tbl[2]  = mk(1, 1, 0, 2'd1, 6'h22, 32'hDEAD,    32'hBEEF,    32'h5,       0, 2'd0, 2'd2, 32'h77,      32'h99,        1, 3'd0, 32'h100,     32'h10,      32'h77,      0);
    tbl[3]  = mk(1, 1, 0, 2'd3, 6'h2A, 32'hCAFE,    32'h1,       32'h6,       0, 2'd0, 2'd2, 32'h77,      32'h98,        1, 3'd0, 32'h100,     32'h10,      32'h77,      0);
    tbl[4]  = mk(0, 1, 0, 2'd2, 6'h25, 32'hF00D,    32'h2,       32'h7,       1, 2'd0, 2'd2, 32'h77,      32'h97,        1, 3'd0, 32'h100,     32'h10,      32'h77,      0);
    tbl[5]  = mk(1, 1, 1, 2'd2, 6'h20, 32'd3,       32'd4,       32'd8,       1, 2'd0, 2'd0, 32'h0,       32'h0,         0, 3'd0, 32'd0,       32'd0,       32'd0,       0);
    tbl[6]  = mk(1, 1, 0, 2'd0, 6'h00, 32'd7,       32'd8,       32'd9,       1, 2'd0, 2'd0, 32'h0,       32'h0,         0, 3'd0, 32'd0,       32'd0,       32'd0,       0);
    tbl[7]  = mk(1, 0, 0, 2'd2, 6'h27, 32'h11,      32'h22,      32'h0,       0, 2'd0, 2'd0, 32'h0,       32'h0,         1, 3'd0, 32'h11,      32'h22,      32'h22,      1);
    tbl[8]  = mk(0, 0, 0, 2'd2, 6'h27, 32'h11,      32'h22,      32'h0,       0, 2'd0, 2'd0, 32'h0,       32'h0,         0, 3'd0, 32'h11,      32'h22,      32'h22,      0);
    tbl[9]  = mk(1, 0, 0, 2'd3, 6'h20, 32'd1,       32'd2,       32'h0,       0, 2'd0, 2'd0, 32'h0,       32'h0,         1, 3'd0, 32'd1,       32'd2,       32'd2,       1);
    tbl[10] = mk(1, 0, 0, 2'd1, 6'h00, 32'd1,       32'd4,       32'h0,       0, 2'd1, 2'd0, 32'h5555,    32'h1234,      1, 3'd1, 32'h1234,    32'd4,       32'd4,       0);
    tbl[11] = mk(1, 0, 0, 2'd1, 6'h00, 32'd1,       32'd4,       32'h0,       0, 2'd3, 2'd0, 32'h5555,    32'h1234,      1, 3'd1, 32'd1,       32'd4,       32'd4,       0);
    tbl[12] = mk(1, 0, 0, 2'd2, 6'h24, 32'd9,       32'h0F,      32'h0,       0, 2'd2, 2'd1, 32'hF0F0,    32'hABCD,      1, 3'd2, 32'hF0F0,    32'hABCD,    32'hABCD,    0);
    tbl[13] = mk(1, 0, 0, 2'd2, 6'h25, 32'd3,       32'd5,       32'h0,       0, 2'd0, 2'd0, 32'h0,       32'h0,         1, 3'd3, 32'd3,       32'd5,       32'd5,       0);
    tbl[14] = mk(1, 0, 0, 2'd2, 6'h22, 32'd3,       32'd5,       32'h0,       0, 2'd0, 2'd3, 32'h0,       32'h0,         1, 3'd1, 32'd3,       32'd5,       32'd5,       0);
    tbl[15] = mk(1, 0, 0, 2'd2, 6'h20, 32'd7,       32'd6,       32'hFFFFFFF0,1, 2'd0, 2'd2, 32'h42,      32'h0,         1, 3'd0, 32'd7,       32'hFFFFFFF0,32'h42,      0);
    tbl[16] = mk(1, 0, 1, 2'd2, 6'h2A, 32'd7,       32'd6,       32'h5,       1, 2'd0, 2'd0, 32'h0,       32'h0,         0, 3'd0, 32'd0,       32'd0,       32'd0,       0);

    // Reset state.
    rst = 1'b1;
    drive(mk(0, 0, 0, 2'd0, 6'h0, '0, '0, '0, 0, 2'd0, 2'd0, '0, '0, 0, 3'd0, '0, '0, '0, 0));
    repeat (2) @(posedge clk);
    #1;
    e = mk(0, 0, 0, 2'd0, 6'h0, '0, '0, '0, 0, 2'd0, 2'd0, '0, '0, 0, 3'd0, '0, '0, '0, 0);
    check_outputs("reset", e);

    // Table vectors through the scoreboard.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst = 1'b0;
      drive(tbl[i]);
      sb.push_back(tbl[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      bump_cnt(e.e_valid);
      check_outputs($sformatf("v%0d", i), e);
    end

    // Saturation: 20 bubbles on a 4-bit counter.
    for (int k = 0; k < 20; k++) begin
      step(0, 0, 0, 0, 32'd1);
      bump_cnt(1'b0);
      check($sformatf("sat%0d.bubble", k), 32'(o_bubble_cnt), 32'(exp_cnt));
    end
    check("sat.final", 32'(o_bubble_cnt), 32'd15);

    // Valid load keeps the saturated count, then reset during stall clears the stage.
    step(0, 1, 0, 0, 32'h5);
    check("load.valid", 32'(o_valid), 32'd1);
    check("load.op_a", o_op_a, 32'h5);
    check("load.bubble", 32'(o_bubble_cnt), 32'd15);
    step(1, 1, 1, 0, 32'h6);
    exp_cnt = 0;
    check("rststall.valid", 32'(o_valid), 32'd0);
    check("rststall.op_a", o_op_a, 32'd0);
    check("rststall.bubble", 32'(o_bubble_cnt), 32'd0);
    // Stall holding the bubble still counts.
    step(0, 1, 1, 0, 32'h7);
    check("stallbub.valid", 32'(o_valid), 32'd0);
    check("stallbub.op_a", o_op_a, 32'd0);
    check("stallbub.bubble", 32'(o_bubble_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_alu_issue.md
Name: id_ex_alu_issue

Overview:
ID/EX pipeline register and ALU-operand issue stage. It sits on the producer side of the execute-stage ALU. It captures decoded instruction fields at the end of ID, turns the main ALUOp plus funct into the 3-bit ALU operation code, and drives the ALU's op_a, op_b and alu_op inputs. Operands are forwarded from EX/MEM and MEM/WB, and the stage supports stall, flush and bubble accounting.

Parameters:
DATA_W, 32, operand/immediate width
CNT_W, 16, bubble counter width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous, active-high reset
i_valid  in  1  ID stage holds a real instruction
i_stall  in  1  hold stage contents (load-use hazard)
i_flush  in  1  replace next contents with bubble (branch taken)
i_alu_op_main  in  2  00 add (lw/sw), 01 sub (beq), 10 R-type (use funct), 11 illegal
i_funct  in  6  instruction funct field
i_rd1  in  DATA_W  register-file read data rs
i_rd2  in  DATA_W  register-file read data rt
i_imm  in  DATA_W  sign-extended immediate
i_alu_src  in  1  1: op_b = immediate
i_fwd_a  in  2  EX-cycle select for op_a: 00 reg, 01 MEM/WB, 10 EX/MEM, 11 reg
i_fwd_b  in  2  same encoding, for rt path
i_ex_mem_result  in  DATA_W  EX/MEM forwarded value
i_mem_wb_result  in  DATA_W  MEM/WB forwarded value
o_valid  out  1  stage holds a real instruction
o_alu_op  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
o_op_a  out  DATA_W  ALU operand A
o_op_b  out  DATA_W  ALU operand B
o_wr_data  out  DATA_W  forwarded rt (store data)
o_illegal  out  1  registered instruction had an undecodable op/funct
o_bubble_cnt  out  CNT_W  saturating count of cycles with o_valid=0

Behaviour:
- Single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset: all stage registers are 0, so o_valid=0, o_alu_op=000, o_illegal=0, o_bubble_cnt=0. o_op_a/o_op_b/o_wr_data follow the forwarding mux over zeroed registers.
- Latency: 1 cycle. Fields sampled at edge N appear on the outputs after edge N.
- Update priority at each edge: i_rst > i_flush > i_stall > load.
  - flush: valid=0, alu_op=000, illegal=0, rd1/rd2/imm/alu_src cleared.
  - stall: every register holds.
  - load: valid=i_valid; all other fields captured. When i_valid=0, the captured control is forced to the bubble values.
- Decode, registered at load:
  - main 00 -> 000; main 01 -> 001.
  - main 10 with funct 0x20 -> 000, 0x22 -> 001, 0x24 -> 010, 0x25 -> 011, 0x2A -> 101.
  - Any other funct, or main 11 -> alu_op=000 and illegal=1. illegal is set only when i_valid=1.
- Forwarding, combinational on the registered values:
  - a_sel = i_fwd_a ? {reg rd1 / mem_wb / ex_mem}; code 11 behaves as 00.
  - b_fwd is selected the same way from rd2 via i_fwd_b.
  - o_wr_data = b_fwd.
  - o_op_b = alu_src_q ? imm_q : b_fwd, so forwarding never overrides the immediate.
  - o_op_a = a_sel.
- Bubble counter: increments at each edge where the post-edge o_valid is 0. This includes stall cycles that hold a bubble. It saturates at all-ones and clears only on reset.
- Flush asserted together with stall: flush wins and a bubble is inserted.
- Reset mid-stall: the stage clears; the stall is ignored that cycle.

Decomposition:
- Shared package holds:
  - ALU op codes: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
  - Main ALUOp codes.
  - Funct constants.
  - Forward-select codes: FWD_REG, FWD_WB, FWD_MEM.
- One sub-module is natural: alu_op_decode, a combinational decoder from main ALUOp and funct to {alu_op, illegal}. It is reusable by the hazard unit.

Test Plan:
- Reset, then load R-type funct 0x2A with rd1=5, rd2=9, fwd=00, alu_src=0 -> next cycle o_valid=1, o_alu_op=101, op_a=5, op_b=9, o_illegal=0.
- Load lw (main 00) with alu_src=1, imm=0x10, rd2=0xAA, i_fwd_b=10, ex_mem=0x77 -> o_alu_op=000, op_b=0x10, o_wr_data=0x77.
- Hold i_stall=1 for 3 cycles while changing inputs -> all outputs unchanged. Then assert i_flush with i_stall -> o_valid=0, o_alu_op=000, o_bubble_cnt increments.
- Load main 10 with funct 0x27 -> o_illegal=1, o_alu_op=000. Repeat with i_valid=0 -> o_illegal=0.
- i_fwd_a=01, mem_wb=0x1234, rd1=1 -> op_a=0x1234. Change to i_fwd_a=11 -> op_a=1.
- With CNT_W=4, feed 20 bubbles -> o_bubble_cnt saturates at 15. Assert i_rst -> counter returns to 0 on the next edge.
